// File: rtl/instdec_queue_if.sv
// Handshake and decoded-field bundle between fetch, the decode queue and execute.
// The queue itself uses the slave view; the fetch/execute environment uses the master view.
interface instdec_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [XLEN-1:0] out_i_imm;
   logic [XLEN-1:0] out_s_imm;
   logic [XLEN-1:0] out_b_imm;
   logic [XLEN-1:0] out_u_imm;
   logic [XLEN-1:0] out_j_imm;
   logic            out_illegal;
   logic [CW-1:0]   count;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
             out_rd, out_rs1, out_rs2, out_i_imm, out_s_imm, out_b_imm,
             out_u_imm, out_j_imm, out_illegal, count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
             out_rd, out_rs1, out_rs2, out_i_imm, out_s_imm, out_b_imm,
             out_u_imm, out_j_imm, out_illegal, count
   );
endinterface

// File: rtl/instdec_queue.sv
// Instruction queue between fetch and execute: circular FIFO of {instr, pc}
// with the head word decoded combinationally into RISC-V fields and immediates.
module instdec_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   instdec_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   cnt;
   logic            push, pop;
   entry_t          head;
   logic [31:0]     w;

   // Readiness looks only at occupancy, so fetch never waits on execute combinationally.
   assign q.in_ready  = cnt < CW'(DEPTH);
   assign q.out_valid = cnt != '0;
   assign q.count     = cnt;

   assign push = q.in_valid  && q.in_ready  && !q.flush;
   assign pop  = q.out_valid && q.out_ready && !q.flush;

   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; stale slots are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= '{instr: q.in_instr, pc: q.in_pc};
   end

   assign head = mem[rd_ptr];
   assign w    = q.out_valid ? head.instr : 32'h0;

   assign q.out_pc      = q.out_valid ? head.pc : '0;
   assign q.out_opcode  = w[6:0];
   assign q.out_rd      = w[11:7];
   assign q.out_funct3  = w[14:12];
   assign q.out_rs1     = w[19:15];
   assign q.out_rs2     = w[24:20];
   assign q.out_funct7  = w[31:25];
   assign q.out_illegal = q.out_valid && (w[1:0] != 2'b11);

   // Size casts of signed operands sign-extend to XLEN.
   assign q.out_i_imm = XLEN'($signed(w[31:20]));
   assign q.out_s_imm = XLEN'($signed({w[31:25], w[11:7]}));
   assign q.out_b_imm = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
   assign q.out_u_imm = XLEN'($signed({w[31:12], 12'b0}));
   assign q.out_j_imm = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
endmodule

// File: tb/tb_instdec_queue.sv
// Randomized bench for instdec_queue against a queue-based reference model
// that decodes fields and immediates arithmetically.
module tb_instdec_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } ent_t;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic [CW-1:0]   cnt;
      logic [XLEN-1:0] pc;
      logic [6:0]      op;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] i;
      logic [XLEN-1:0] s;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] u;
      logic [XLEN-1:0] j;
      logic            ill;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nmis = 0;
   ent_t model[$];

   always #5 clk = ~clk;

   instdec_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) q ();

   instdec_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .q   (q)
   );

   function automatic logic [XLEN-1:0] trunc(input longint v);
      return XLEN'(v);
   endfunction

   // Reference decode from the field/immediate rules using integer arithmetic.
   function automatic obs_t expect_obs();
      obs_t   e;
      logic [31:0] x;
      longint v;
      e       = '0;
      e.cnt   = CW'(model.size());
      e.ready = model.size() < DEPTH;
      e.valid = model.size() != 0;
      if (!e.valid) return e;
      x    = model[0].instr;
      e.pc = model[0].pc;
      e.op = x[6:0];   e.rd  = x[11:7];  e.f3  = x[14:12];
      e.rs1 = x[19:15]; e.rs2 = x[24:20]; e.f7 = x[31:25];
      e.ill = x[1:0] != 2'b11;
      v = longint'(x[31:20]);                              if (x[31]) v -= 4096;   e.i = trunc(v);
      v = longint'(x[31:25]) * 32 + longint'(x[11:7]);     if (x[31]) v -= 4096;   e.s = trunc(v);
      v = longint'(x[31]) * 4096 + longint'(x[7]) * 2048 + longint'(x[30:25]) * 32
          + longint'(x[11:8]) * 2;                         if (x[31]) v -= 8192;   e.b = trunc(v);
      v = longint'(x[31:12]) * 4096;                       if (x[31]) v -= 64'sh1_0000_0000; e.u = trunc(v);
      v = longint'(x[31]) * (1 << 20) + longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048
          + longint'(x[30:21]) * 2;                        if (x[31]) v -= (1 << 21); e.j = trunc(v);
      return e;
   endfunction

   function automatic obs_t act();
      obs_t a;
      a.valid = q.out_valid;  a.ready = q.in_ready;   a.cnt = q.count;
      a.pc    = q.out_pc;     a.op    = q.out_opcode; a.f3  = q.out_funct3;
      a.f7    = q.out_funct7; a.rd    = q.out_rd;     a.rs1 = q.out_rs1;
      a.rs2   = q.out_rs2;    a.i     = q.out_i_imm;  a.s   = q.out_s_imm;
      a.b     = q.out_b_imm;  a.u     = q.out_u_imm;  a.j   = q.out_j_imm;
      a.ill   = q.out_illegal;
      return a;
   endfunction

   // Drive one cycle, advance the model at the edge, land 1 time unit after it.
   task automatic step(input logic iv, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic orr, input logic fl, input logic r);
      bit do_push, do_pop;
      q.in_valid = iv; q.in_instr = ins; q.in_pc = pc;
      q.out_ready = orr; q.flush = fl; rst = r;
      @(posedge clk);
      if (r || fl) model.delete();
      else begin
         do_pop  = orr && model.size() != 0;
         do_push = iv && model.size() < DEPTH;
         if (do_pop) void'(model.pop_front());
         if (do_push) model.push_back('{instr: ins, pc: pc});
      end
      #1;
      q.in_valid = 1'b0; q.out_ready = 1'b0; q.flush = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e, a;
      step(0, 32'h0, '0, 0, 0, 1);
      step(0, 32'h0, '0, 0, 0, 1);
      e = expect_obs(); a = act(); nvec++;
      if (a !== e) begin nmis++; $display("FAIL reset obs got=%h exp=%h", a, e); end
      nvec++;
      if (q.in_ready !== 1'b1 || q.count !== '0 || q.out_valid !== 1'b0) begin
         nmis++; $display("FAIL reset_flags rdy=%b cnt=%0d vld=%b exp 1/0/0", q.in_ready, q.count, q.out_valid);
      end
   endtask

   task automatic test_single_push();
      obs_t e, a;
      step(1, 32'h00500093, XLEN'(32'h100), 0, 0, 0);
      e = expect_obs(); a = act(); nvec++;
      if (a !== e) begin nmis++; $display("FAIL single_push obs got=%h exp=%h", a, e); end
      nvec++;
      if (q.out_valid !== 1'b1 || q.out_pc !== XLEN'(32'h100) || q.out_opcode !== 7'h13 ||
          q.out_rd !== 5'd1 || q.out_rs1 !== 5'd0 || q.out_i_imm !== XLEN'(5) || q.count !== CW'(1)) begin
         nmis++; $display("FAIL addi_fields pc=%h op=%h rd=%0d imm=%h cnt=%0d exp 100/13/1/5/1",
                          q.out_pc, q.out_opcode, q.out_rd, q.out_i_imm, q.count);
      end
      step(0, 32'h0, '0, 1, 0, 0);
      e = expect_obs(); a = act(); nvec++;
      if (a !== e) begin nmis++; $display("FAIL single_pop obs got=%h exp=%h", a, e); end
   endtask

   task automatic test_branch();
      logic [XLEN-1:0] m4;
      m4 = '1; m4 = m4 - XLEN'(3);
      step(1, 32'hFE000EE3, XLEN'(32'h200), 0, 0, 0);
      nvec++;
      if (q.out_b_imm !== m4 || q.out_opcode !== 7'h63) begin
         nmis++; $display("FAIL branch_imm b=%h op=%h exp %h/63", q.out_b_imm, q.out_opcode, m4);
      end
      step(0, 32'h0, '0, 1, 0, 0);
   endtask

   task automatic test_backpressure();
      obs_t e, a;
      for (int k = 0; k < 5; k++) begin
         step(1, $urandom, XLEN'(32'h1000 + 4 * k), 0, 0, 0);
         if (k == 3) begin
            nvec++;
            if (q.in_ready !== 1'b0 || q.count !== CW'(4)) begin
               nmis++; $display("FAIL full_flag rdy=%b cnt=%0d exp 0/4", q.in_ready, q.count);
            end
         end
      end
      e = expect_obs(); a = act(); nvec++;
      if (a !== e || q.out_pc !== XLEN'(32'h1000)) begin
         nmis++; $display("FAIL full_hold obs got=%h exp=%h", a, e);
      end
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q.out_pc !== XLEN'(32'h1000 + 4 * k)) begin
            nmis++; $display("FAIL drain_order pc=%h exp=%h", q.out_pc, XLEN'(32'h1000 + 4 * k));
         end
         step(0, 32'h0, '0, 1, 0, 0);
         e = expect_obs(); a = act(); nvec++;
         if (a !== e) begin nmis++; $display("FAIL drain obs got=%h exp=%h", a, e); end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, a;
      step(1, $urandom, XLEN'($urandom), 0, 0, 0);
      step(1, $urandom, XLEN'($urandom), 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         step(1, $urandom, XLEN'($urandom), 1, 0, 0);
         e = expect_obs(); a = act(); nvec++;
         if (a !== e || q.count !== CW'(2)) begin
            nmis++; $display("FAIL push_pop cyc=%0d obs got=%h exp=%h", k, a, e);
         end
      end
   endtask

   task automatic test_flush();
      obs_t e, a;
      step(1, $urandom, XLEN'($urandom), 0, 0, 0);
      step(1, 32'h00000013, XLEN'(32'h300), 1, 1, 0);
      e = expect_obs(); a = act(); nvec++;
      if (a !== e || q.count !== '0 || q.out_valid !== 1'b0) begin
         nmis++; $display("FAIL flush obs got=%h exp=%h", a, e);
      end
      step(0, 32'h0, '0, 0, 0, 0);
      nvec++;
      if (q.out_valid !== 1'b0 || q.count !== '0) begin
         nmis++; $display("FAIL flush_drop vld=%b cnt=%0d exp 0/0", q.out_valid, q.count);
      end
   endtask

   task automatic test_reset_illegal();
      for (int k = 0; k < 3; k++) step(1, $urandom, XLEN'($urandom), 0, 0, 0);
      nvec++;
      if (q.count !== CW'(3)) begin nmis++; $display("FAIL pre_reset cnt=%0d exp 3", q.count); end
      step(1, $urandom, XLEN'($urandom), 1, 1, 1);
      nvec++;
      if (q.count !== '0 || q.out_valid !== 1'b0 || q.out_pc !== '0) begin
         nmis++; $display("FAIL mid_reset cnt=%0d vld=%b pc=%h exp 0/0/0", q.count, q.out_valid, q.out_pc);
      end
      step(1, 32'h0, XLEN'(32'h400), 0, 0, 0);
      nvec++;
      if (q.out_illegal !== 1'b1 || q.out_valid !== 1'b1) begin
         nmis++; $display("FAIL illegal ill=%b vld=%b exp 1/1", q.out_illegal, q.out_valid);
      end
      step(0, 32'h0, '0, 1, 0, 0);
   endtask

   task automatic test_random();
      obs_t e, a;
      logic [31:0] ins;
      for (int k = 0; k < 400; k++) begin
         ins = $urandom;
         if ($urandom_range(0, 3) != 0) ins[1:0] = 2'b11;
         step($urandom_range(0, 2) != 0, ins, XLEN'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
         e = expect_obs(); a = act(); nvec++;
         if (a !== e) begin nmis++; $display("FAIL random cyc=%0d obs got=%h exp=%h", k, a, e); end
      end
   endtask

   initial begin
      rst = 1'b1;
      q.in_valid = 1'b0; q.in_instr = '0; q.in_pc = '0;
      q.out_ready = 1'b0; q.flush = 1'b0;
      #1;
      test_reset();
      test_single_push();
      test_branch();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_illegal();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
